dot_product_drain: RTL

- Consumer-side companion to the dot-product pipeline.
- Gates new Vec3 pairs into the pipeline and drives the pipeline's `proceed`.
- Tracks which pipeline slots hold real work with a valid-token shift register.
- Captures each finished UCBFloat result, converts it back to 64-bit IEEE 754 with UCBFloatDecoder, and buffers it in a FIFO behind a valid/ready output.

---
 rtl/dot_product_drain_if.sv | 39 +++
 rtl/dot_product_drain.sv | 133 +++++++++++++
 2 files changed

// File: rtl/dot_product_drain_if.sv
// Handshake and status bundle between the dot-product drain and its producer/consumer.
// The drain itself connects through the slave modport.
interface dot_product_drain_if #(
    parameter int unsigned CNTW = 4
) ();
    logic            issue_valid;
    logic            issue_ready;
    logic            proceed;
    logic [64:0]     result;
    logic            out_valid;
    logic            out_ready;
    logic [63:0]     out_data;
    logic [CNTW-1:0] count;
    logic [CNTW-1:0] inflight;

    modport master (
        output issue_valid,
        output result,
        output out_ready,
        input  issue_ready,
        input  proceed,
        input  out_valid,
        input  out_data,
        input  count,
        input  inflight
    );

    modport slave (
        input  issue_valid,
        input  result,
        input  out_ready,
        output issue_ready,
        output proceed,
        output out_valid,
        output out_data,
        output count,
        output inflight
    );
endinterface

// File: rtl/dot_product_drain.sv
// Consumer side of the dot-product pipeline: gates issue, tracks in-flight work with
// valid tokens, converts finished recoded results to IEEE double and buffers them.
module dot_product_drain #(
    parameter int unsigned LATENCY = 12,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned CNTW    = $clog2(DEPTH + 1)
) (
    input logic                clk,
    input logic                reset,
    dot_product_drain_if.slave bus
);
    localparam int unsigned     PTRW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTRW-1:0] LAST_PTR = PTRW'(DEPTH - 1);

    logic [LATENCY-1:0] tok_q, tok_d;
    logic [CNTW-1:0]    count_q, count_d;
    logic [CNTW-1:0]    inflight_q, inflight_d;
    logic [PTRW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [63:0]        mem_q [DEPTH];

    logic        accept;
    logic        push;
    logic        pop;
    logic        proceed;
    logic        issue_ready;
    logic        out_valid;
    logic [CNTW:0] occupancy;

    // Recoded-to-IEEE decode of the pipeline output.
    logic        dec_sign;
    logic [11:0] dec_exp;
    logic [51:0] dec_fract;
    logic        dec_is_zero;
    logic        dec_is_inf;
    logic        dec_is_nan;
    logic        dec_is_sub;
    logic [5:0]  dec_dist;
    logic [51:0] dec_fract_den;
    logic [10:0] dec_exp_out;
    logic [51:0] dec_fract_out;
    logic [63:0] dec_data;

    always_comb begin
        dec_sign      = bus.result[64];
        dec_exp       = bus.result[63:52];
        dec_fract     = bus.result[51:0];
        dec_is_zero   = (dec_exp[11:9] == 3'b000);
        dec_is_inf    = (dec_exp[11:9] == 3'b110);
        dec_is_nan    = (dec_exp[11:9] == 3'b111);
        dec_is_sub    = (dec_exp < 12'h402);
        // Subnormals: re-insert the hidden bit and shift it down to the fixed exponent.
        dec_dist      = 6'd1 - dec_exp[5:0];
        dec_fract_den = {~dec_is_zero, dec_fract[51:1]} >> dec_dist;
        dec_exp_out   = dec_is_sub ? 11'd0 : (dec_exp[10:0] - 11'h401);
        dec_exp_out   = dec_exp_out | {11{dec_is_inf | dec_is_nan}};
        if (dec_is_sub) begin
            dec_fract_out = dec_fract_den;
        end else if (dec_is_inf) begin
            dec_fract_out = '0;
        end else begin
            dec_fract_out = dec_fract;
        end
        dec_data = {dec_sign, dec_exp_out, dec_fract_out};
    end

    // A slot is reserved for every token in flight, so a push always finds room.
    assign occupancy   = {1'b0, count_q} + {1'b0, inflight_q};
    assign issue_ready = ~reset & (occupancy < (CNTW + 1)'(DEPTH));
    assign accept      = bus.issue_valid & issue_ready;
    assign proceed     = ~reset & (accept | (inflight_q != '0));
    assign push        = proceed & tok_q[LATENCY-1];
    assign out_valid   = (count_q != '0);
    assign pop         = out_valid & bus.out_ready;

    always_comb begin
        tok_d = tok_q;
        if (proceed) begin
            tok_d[0] = accept;
            for (int unsigned k = 1; k < LATENCY; k++) begin
                tok_d[k] = tok_q[k-1];
            end
        end
    end

    always_comb begin
        count_d    = count_q + CNTW'(push) - CNTW'(pop);
        inflight_d = inflight_q + CNTW'(accept) - CNTW'(push);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tok_q      <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            tok_q      <= tok_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Storage needs no reset: out_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= dec_data;
        end
    end

    assign bus.issue_ready = issue_ready;
    assign bus.proceed     = proceed;
    assign bus.out_valid   = out_valid;
    assign bus.out_data    = out_valid ? mem_q[rd_ptr_q] : 64'h0;
    assign bus.count       = count_q;
    assign bus.inflight    = inflight_q;

    a_occupancy_bound: assert property (@(posedge clk) disable iff (reset)
        occupancy <= (CNTW + 1)'(DEPTH));
    a_push_has_room: assert property (@(posedge clk) disable iff (reset)
        push |-> (count_q < CNTW'(DEPTH)) || pop);
endmodule
